cic_dec_ctrl: RTL and testbench

//  Sequencer for the CIC decimator chain: N integrator stages -> decimate by R -> N comb stages.
//  - Gates the integrator enable with the input valid.
//  - Counts accepted samples and issues the decimated comb enable.
//  - Clears the stage registers before each run, then masks the first N (warm-up) outputs.
//  - Drains the pipeline on stop.

---
 rtl/cic_dec_ctrl.sv | 121 ++++++++++++
 tb/tb_cic_dec_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cic_dec_ctrl.sv
// Sequencer for a CIC decimator: gates integrators, strobes the comb chain every R accepted
// samples, clears stages before a run, masks the first N outputs and drains on stop.
module cic_dec_ctrl #(
   parameter int unsigned WR        = 5,
   parameter int unsigned N         = 3,
   parameter int unsigned INT_LAT   = 3,
   parameter int unsigned COMB_LAT  = 3,
   parameter int unsigned FLUSH_CYC = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_stop,
   input  logic [WR-1:0] i_ratio,
   input  logic          i_val_in,
   output logic          o_int_en,
   output logic          o_comb_en,
   output logic          o_stage_clr,
   output logic          o_val_out,
   output logic [WR-1:0] o_dec_phase,
   output logic          o_busy,
   output logic          o_cfg_err
);

   localparam int unsigned KL = INT_LAT + COMB_LAT;
   localparam int unsigned FW = $clog2(FLUSH_CYC + 1);
   localparam int unsigned WW = $clog2(N + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FLUSH  = 3'd1;
   localparam logic [2:0] S_WARMUP = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [WR-1:0]      r_ratio;
   logic [WR-1:0]      r_dec_phase;
   logic [FW-1:0]      r_flush_cnt;
   logic [WW-1:0]      r_warm_cnt;
   logic [INT_LAT-1:0] r_stb_dl;
   logic [KL-1:0]      r_keep_dl;
   logic               r_cfg_err;

   logic               w_active;
   logic               w_int_en;
   logic               w_strobe;
   logic               w_start_ok;
   logic               w_start_bad;
   logic [INT_LAT-1:0] w_stb_nxt;
   logic [KL-1:0]      w_keep_nxt;

   assign w_active    = (r_state == S_WARMUP) || (r_state == S_RUN);
   assign w_int_en    = i_val_in && w_active;
   assign w_strobe    = w_int_en && (r_dec_phase == (r_ratio - WR'(1)));
   assign w_start_ok  = (r_state == S_IDLE) && i_start && (i_ratio >= WR'(2));
   assign w_start_bad = (r_state == S_IDLE) && i_start && (i_ratio < WR'(2));

   // Only strobes taken in RUN carry keep=1; warm-up strobes travel as zeros.
   assign w_stb_nxt  = (r_stb_dl << 1) | INT_LAT'(w_strobe);
   assign w_keep_nxt = (r_keep_dl << 1) | KL'(w_strobe && (r_state == S_RUN));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start_ok) w_state_nxt = S_FLUSH;
         S_FLUSH:  if (r_flush_cnt == FW'(FLUSH_CYC - 1)) w_state_nxt = S_WARMUP;
         S_WARMUP: begin
            if (i_stop) begin
               w_state_nxt = S_DRAIN;
            end else if (w_strobe && (r_warm_cnt == WW'(N - 1))) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN:    if (i_stop) w_state_nxt = S_DRAIN;
         // Leave once the lines hold nothing beyond what is emitted this cycle.
         S_DRAIN:  if ((w_stb_nxt == '0) && (w_keep_nxt == '0)) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ratio     <= '0;
         r_dec_phase <= '0;
         r_flush_cnt <= '0;
         r_warm_cnt  <= '0;
         r_stb_dl    <= '0;
         r_keep_dl   <= '0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_stb_dl  <= w_stb_nxt;
         r_keep_dl <= w_keep_nxt;
         r_cfg_err <= w_start_bad;

         if (w_start_ok) begin
            r_ratio     <= i_ratio;
            r_dec_phase <= '0;
            r_warm_cnt  <= '0;
         end else if (w_int_en) begin
            r_dec_phase <= w_strobe ? '0 : r_dec_phase + WR'(1);
         end

         if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + FW'(1);
         else                    r_flush_cnt <= '0;

         if ((r_state == S_WARMUP) && w_strobe) r_warm_cnt <= r_warm_cnt + WW'(1);
      end
   end

   assign o_int_en    = w_int_en;
   assign o_comb_en   = r_stb_dl[INT_LAT-1];
   assign o_val_out   = r_keep_dl[KL-1];
   assign o_stage_clr = (r_state == S_FLUSH);
   assign o_dec_phase = r_dec_phase;
   assign o_busy      = (r_state != S_IDLE);
   assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: run timing, cfg errors, gapped input, stop/drain, async reset.
module tb_cic_dec_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, val_in;
   logic [4:0] ratio;
   logic       int_en, comb_en, stage_clr, val_out, busy, cfg_err;
   logic [4:0] dec_phase;

   int n_cmp = 0;
   int n_bad = 0;

   cic_dec_ctrl #(
      .WR        (5),
      .N         (3),
      .INT_LAT   (3),
      .COMB_LAT  (3),
      .FLUSH_CYC (2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_stop      (stop),
      .i_ratio     (ratio),
      .i_val_in    (val_in),
      .o_int_en    (int_en),
      .o_comb_en   (comb_en),
      .o_stage_clr (stage_clr),
      .o_val_out   (val_out),
      .o_dec_phase (dec_phase),
      .o_busy      (busy),
      .o_cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_int_en"}, int_en, 0);
      chk({tag, "_comb_en"}, comb_en, 0);
      chk({tag, "_stage_clr"}, stage_clr, 0);
      chk({tag, "_val_out"}, val_out, 0);
      chk({tag, "_dec_phase"}, dec_phase, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 0; stop = 0; val_in = 0; ratio = 0;
      #1;
      chk_all_zero("reset");
      tick();
      #2 rst_n = 1'b1;
      tick();

      // Test 1 + 4: ratio 4, continuous input, ratio changed mid-run, stop on a RUN strobe.
      start = 1; ratio = 4;
      tick();
      start = 0; ratio = 7; val_in = 1;
      chk("t1_flush1_clr", stage_clr, 1);
      chk("t1_flush1_int_en", int_en, 0);
      chk("t1_flush1_busy", busy, 1);
      tick();
      chk("t1_flush2_clr", stage_clr, 1);
      chk("t1_flush2_int_en", int_en, 0);
      tick();
      for (int c = 3; c <= 37; c++) begin
         int k, ke, kv;
         k  = c - 2;
         ke = c - 5;
         kv = c - 8;
         start = (c == 10);
         if (c == 10) ratio = 2;
         stop  = (c == 30);
         chk("t1_stage_clr", stage_clr, 0);
         chk("t1_int_en", int_en, (c <= 30) ? 1 : 0);
         chk("t1_dec_phase", dec_phase, (c <= 30) ? (k - 1) % 4 : 0);
         chk("t1_comb_en", comb_en, (ke >= 4 && ke % 4 == 0 && ke <= 28) ? 1 : 0);
         chk("t1_val_out", val_out, (kv >= 16 && kv % 4 == 0 && kv <= 28) ? 1 : 0);
         chk("t1_busy", busy, (c <= 36) ? 1 : 0);
         tick();
      end
      start = 0; stop = 0; val_in = 0;

      // Test 2: ratio below 2 is rejected with a one-cycle cfg_err.
      for (int r = 0; r < 2; r++) begin
         start = 1; ratio = 5'(r);
         tick();
         start = 0;
         chk("t2_cfg_err_hi", cfg_err, 1);
         chk("t2_busy_hi", busy, 0);
         tick();
         chk("t2_cfg_err_lo", cfg_err, 0);
         chk("t2_busy_lo", busy, 0);
      end

      // Test 3: start+stop together (start wins), ratio 3, input valid every other cycle.
      start = 1; stop = 1; ratio = 3;
      tick();
      start = 0; stop = 0;
      chk("t3_busy", busy, 1);
      chk("t3_stage_clr", stage_clr, 1);
      tick();
      tick();
      for (int c = 3; c <= 24; c++) begin
         val_in = ((c - 3) % 2 == 0);
         stop   = (c == 24);
         chk("t3_dec_phase", dec_phase, ((c - 2) / 2) % 3);
         chk("t3_comb_en", comb_en, (c >= 10 && (c - 10) % 6 == 0) ? 1 : 0);
         chk("t3_val_out", val_out, 0);
         tick();
      end
      stop = 0; val_in = 0;
      chk("t3_drain_busy", busy, 1);
      tick();
      chk("t3_idle_busy", busy, 0);
      tick();

      // Test 5: async reset in WARMUP with a comb_en on the output and strobes in flight.
      start = 1; ratio = 4;
      tick();
      start = 0; val_in = 1;
      for (int c = 1; c <= 8; c++) tick();
      chk("t5_pre_comb_en", comb_en, 1);
      chk("t5_pre_dec_phase", dec_phase, 2);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t5_rst");
      #2 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t5_post_comb_en", comb_en, 0);
         chk("t5_post_busy", busy, 0);
      end

      // Restart with ratio 5: three warm-up outputs masked again.
      start = 1; ratio = 5;
      tick();
      start = 0;
      tick();
      tick();
      for (int c = 3; c <= 34; c++) begin
         int ke, kv;
         ke = c - 5;
         kv = c - 8;
         stop = (c == 30);
         chk("t5_comb_en", comb_en, (ke >= 5 && ke % 5 == 0 && ke <= 28) ? 1 : 0);
         chk("t5_val_out", val_out, (kv >= 20 && kv % 5 == 0 && kv <= 28) ? 1 : 0);
         chk("t5_busy", busy, (c <= 33) ? 1 : 0);
         tick();
      end
      stop = 0; val_in = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
